// File: rtl/redraw_scheduler_if.sv
// Game-side / drawer-side signal bundle for the redraw scheduler.
// The master drives game state and drawer completion; the slave is the scheduler.
interface redraw_scheduler_if;
  logic [2:0] iState;
  logic       iForce;
  logic       iDrawDone;
  logic [2:0] oFrameSel;
  logic       oDrawStart;
  logic       oDrawEnable;
  logic       oBusy;
  logic       oPending;
  logic       oTimeout;
  logic [7:0] oFrameCount;

  modport master (
    output iState, iForce, iDrawDone,
    input  oFrameSel, oDrawStart, oDrawEnable, oBusy, oPending, oTimeout, oFrameCount
  );

  modport slave (
    input  iState, iForce, iDrawDone,
    output oFrameSel, oDrawStart, oDrawEnable, oBusy, oPending, oTimeout, oFrameCount
  );
endinterface

// File: rtl/redraw_scheduler.sv
// Schedules one full-frame redraw per game-state change (or forced redraw),
// keeping only the newest request and never preempting a running draw.
module redraw_scheduler #(
  parameter int DRAW_TIMEOUT = 20000,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                iClock,
  input  logic                iResetn,
  redraw_scheduler_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DRAW  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam int              GW         = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0]   GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0]   GAP_ONE    = GW'(1);
  localparam logic [14:0]     TIMER_LAST = 15'(DRAW_TIMEOUT - 1);
  localparam logic [2:0]      INVALID_ST = 3'd7;

  logic [1:0]    state_q, state_d;
  logic [2:0]    s_state_q, s_state_d;
  logic          pend_valid_q, pend_valid_d;
  logic [2:0]    pend_frame_q, pend_frame_d;
  logic [2:0]    frame_sel_q, frame_sel_d;
  logic [14:0]   timer_q, timer_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    frame_count_q, frame_count_d;

  logic       state_valid;
  logic       req;
  logic [2:0] req_frame;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d       = state_q;
    s_state_d     = s_state_q;
    pend_valid_d  = pend_valid_q;
    pend_frame_d  = pend_frame_q;
    frame_sel_d   = frame_sel_q;
    timer_d       = timer_q;
    gap_cnt_d     = gap_cnt_q;
    timeout_d     = timeout_q;
    frame_count_d = frame_count_q;

    // State 7 is ignored for tracking, but a force still redraws the last valid state.
    state_valid = (bus.iState != INVALID_ST);
    req         = (state_valid && (bus.iState != s_state_q)) || bus.iForce;
    req_frame   = state_valid ? bus.iState : s_state_q;

    if (state_valid) s_state_d = bus.iState;

    if (req) begin
      pend_valid_d = 1'b1;
      pend_frame_d = req_frame;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) begin
          state_d     = ST_START;
          frame_sel_d = pend_frame_q;
          // A request landing on the consuming edge must survive.
          if (!req) pend_valid_d = 1'b0;
        end
      end
      ST_START: begin
        state_d = ST_DRAW;
        timer_d = '0;
      end
      ST_DRAW: begin
        if (bus.iDrawDone) begin
          state_d       = ST_GAP;
          gap_cnt_d     = '0;
          timer_d       = '0;
          frame_count_d = frame_count_q + 8'd1;
        end else if (timer_q == TIMER_LAST) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
          timer_d   = '0;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 15'd1;
        end
      end
      default: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                       gap_cnt_d = gap_cnt_q + GAP_ONE;
      end
    endcase
  end

  // Reset leaves frame 0 queued so the Start screen appears without a request.
  always_ff @(posedge iClock) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!iResetn) begin
      state_q       <= ST_IDLE;
      s_state_q     <= 3'd0;
      pend_valid_q  <= 1'b1;
      pend_frame_q  <= 3'd0;
      frame_sel_q   <= 3'd0;
      timer_q       <= '0;
      gap_cnt_q     <= '0;
      timeout_q     <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      s_state_q     <= s_state_d;
      pend_valid_q  <= pend_valid_d;
      pend_frame_q  <= pend_frame_d;
      frame_sel_q   <= frame_sel_d;
      timer_q       <= timer_d;
      gap_cnt_q     <= gap_cnt_d;
      timeout_q     <= timeout_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign bus.oFrameSel   = frame_sel_q;
  assign bus.oDrawStart  = (state_q == ST_START);
  assign bus.oDrawEnable = (state_q == ST_DRAW);
  assign bus.oBusy       = (state_q != ST_IDLE);
  assign bus.oPending    = pend_valid_q;
  assign bus.oTimeout    = timeout_q;
  assign bus.oFrameCount = frame_count_q;

endmodule

// File: tb/tb_redraw_scheduler.sv
// Directed bench: dut_a uses default parameters (full 19200-cycle draw),
// dut_b uses DRAW_TIMEOUT=100 for the timeout and counter-wrap cases.
module tb_redraw_scheduler;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   seen_frame2 = 0;

  always #5 clk = ~clk;

  redraw_scheduler_if bus_a ();
  redraw_scheduler_if bus_b ();

  redraw_scheduler dut_a (
    .iClock  (clk),
    .iResetn (rst_a_n),
    .bus     (bus_a.slave)
  );

  redraw_scheduler #(.DRAW_TIMEOUT(100), .GAP_CYCLES(2)) dut_b (
    .iClock  (clk),
    .iResetn (rst_b_n),
    .bus     (bus_b.slave)
  );

  always @(negedge clk)
    if (bus_a.oDrawStart && bus_a.oFrameSel == 3'd2) seen_frame2++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One forced redraw on dut_b with an immediate drawer completion.
  task automatic b_force_draw();
    bus_b.iForce = 1'b1;
    tick();
    bus_b.iForce = 1'b0;
    tick();                       // START
    tick();                       // DRAW
    bus_b.iDrawDone = 1'b1;
    tick();                       // GAP
    bus_b.iDrawDone = 1'b0;
    tick();
    tick();                       // IDLE
  endtask

  initial begin
    int n;
    bus_a.iState = 3'd0; bus_a.iForce = 1'b0; bus_a.iDrawDone = 1'b0;
    bus_b.iState = 3'd0; bus_b.iForce = 1'b0; bus_b.iDrawDone = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_busy",     32'(bus_a.oBusy),       32'd0);
    check("rst_enable",   32'(bus_a.oDrawEnable), 32'd0);
    check("rst_start",    32'(bus_a.oDrawStart),  32'd0);
    check("rst_timeout",  32'(bus_a.oTimeout),    32'd0);
    check("rst_count",    32'(bus_a.oFrameCount), 32'd0);
    check("rst_framesel", 32'(bus_a.oFrameSel),   32'd0);
    check("rst_pending",  32'(bus_a.oPending),    32'd1);

    // Start screen after release, 19200-cycle draw
    rst_a_n = 1'b1;
    tick();
    check("s1_start",     32'(bus_a.oDrawStart),  32'd1);
    check("s1_framesel",  32'(bus_a.oFrameSel),   32'd0);
    check("s1_pend_clr",  32'(bus_a.oPending),    32'd0);
    tick();
    check("s1_enable",    32'(bus_a.oDrawEnable), 32'd1);
    check("s1_start_low", 32'(bus_a.oDrawStart),  32'd0);
    repeat (19199) tick();
    check("s1_enable_end", 32'(bus_a.oDrawEnable), 32'd1);
    bus_a.iDrawDone = 1'b1;
    tick();
    bus_a.iDrawDone = 1'b0;
    check("s1_count",     32'(bus_a.oFrameCount), 32'd1);
    check("s1_gap_en",    32'(bus_a.oDrawEnable), 32'd0);
    check("s1_gap1_busy", 32'(bus_a.oBusy),       32'd1);
    tick();
    check("s1_gap2_busy", 32'(bus_a.oBusy),       32'd1);
    tick();
    check("s1_idle",      32'(bus_a.oBusy),       32'd0);

    // Newest pending frame wins
    bus_a.iState = 3'd1;
    tick();
    check("s2_pend",      32'(bus_a.oPending),    32'd1);
    check("s2_no_start",  32'(bus_a.oDrawStart),  32'd0);
    tick();
    check("s2_start1",    32'(bus_a.oDrawStart),  32'd1);
    check("s2_sel1",      32'(bus_a.oFrameSel),   32'd1);
    tick();
    bus_a.iState = 3'd2;
    tick();
    check("s2_pend2",     32'(bus_a.oPending),    32'd1);
    bus_a.iState = 3'd4;
    tick();
    check("s2_pend4",     32'(bus_a.oPending),    32'd1);
    check("s2_no_preempt", 32'(bus_a.oDrawEnable), 32'd1);
    bus_a.iDrawDone = 1'b1;
    tick();
    bus_a.iDrawDone = 1'b0;
    check("s2_count",     32'(bus_a.oFrameCount), 32'd2);
    check("s2_sel_hold",  32'(bus_a.oFrameSel),   32'd1);
    tick(); tick();
    check("s2_idle_sel",  32'(bus_a.oFrameSel),   32'd1);
    tick();
    check("s2_start4",    32'(bus_a.oDrawStart),  32'd1);
    check("s2_sel4",      32'(bus_a.oFrameSel),   32'd4);
    tick();
    bus_a.iDrawDone = 1'b1;
    tick();
    bus_a.iDrawDone = 1'b0;
    tick(); tick();
    check("s2_count3",    32'(bus_a.oFrameCount), 32'd3);
    check("s2_idle",      32'(bus_a.oBusy),       32'd0);

    // Invalid state 7 ignored, force redraws held state 4
    bus_a.iState = 3'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("s3_no_req", 32'({bus_a.oPending, bus_a.oDrawStart}), 32'd0);
    end
    bus_a.iForce = 1'b1;
    tick();
    bus_a.iForce = 1'b0;
    check("s3_force_pend", 32'(bus_a.oPending),   32'd1);
    tick();
    check("s3_start",     32'(bus_a.oDrawStart),  32'd1);
    check("s3_sel",       32'(bus_a.oFrameSel),   32'd4);
    tick();
    bus_a.iDrawDone = 1'b1;
    tick();
    bus_a.iDrawDone = 1'b0;
    tick(); tick();
    bus_a.iState = 3'd4;
    bus_a.iDrawDone = 1'b1;
    tick();
    bus_a.iDrawDone = 1'b0;
    check("s3_done_idle_ign", 32'(bus_a.oFrameCount), 32'd4);
    check("s3_idle",      32'(bus_a.oBusy),       32'd0);
    check("s3_no_pend",   32'(bus_a.oPending),    32'd0);

    // Reset mid-draw at timer=50
    bus_a.iState = 3'd3;
    tick(); tick(); tick();
    repeat (50) tick();
    check("s5_in_draw",   32'(bus_a.oDrawEnable), 32'd1);
    rst_a_n = 1'b0;
    bus_a.iState = 3'd0;
    tick();
    check("s5_abort_en",  32'(bus_a.oDrawEnable), 32'd0);
    check("s5_count",     32'(bus_a.oFrameCount), 32'd0);
    check("s5_pend",      32'(bus_a.oPending),    32'd1);
    rst_a_n = 1'b1;
    tick();
    check("s5_restart",   32'(bus_a.oDrawStart),  32'd1);
    check("s5_sel0",      32'(bus_a.oFrameSel),   32'd0);
    check("s2_never_frame2", 32'(seen_frame2),    32'd0);

    // Timeout with DRAW_TIMEOUT=100 on dut_b
    rst_b_n = 1'b1;
    tick();
    check("s4_start",     32'(bus_b.oDrawStart),  32'd1);
    tick();
    n = 0;
    while (bus_b.oDrawEnable && n < 300) begin
      n++;
      tick();
    end
    check("s4_draw_len",  32'(n),                 32'd100);
    check("s4_timeout",   32'(bus_b.oTimeout),    32'd1);
    check("s4_count",     32'(bus_b.oFrameCount), 32'd0);
    tick(); tick();
    check("s4_idle",      32'(bus_b.oBusy),       32'd0);
    bus_b.iState = 3'd5;
    tick(); tick();
    check("s4_next_start", 32'(bus_b.oDrawStart), 32'd1);
    check("s4_next_sel",  32'(bus_b.oFrameSel),   32'd5);
    tick();
    bus_b.iDrawDone = 1'b1;
    tick();
    bus_b.iDrawDone = 1'b0;
    check("s4_next_count", 32'(bus_b.oFrameCount), 32'd1);
    check("s4_sticky",    32'(bus_b.oTimeout),    32'd1);
    tick(); tick();

    // Done coincident with timeout counts as completion
    rst_b_n = 1'b0;
    bus_b.iState = 3'd0;
    tick();
    check("s6_rst_timeout", 32'(bus_b.oTimeout),  32'd0);
    rst_b_n = 1'b1;
    tick();
    tick();
    repeat (99) tick();
    check("s6_last_cycle", 32'(bus_b.oDrawEnable), 32'd1);
    bus_b.iDrawDone = 1'b1;
    tick();
    bus_b.iDrawDone = 1'b0;
    check("s6_count",     32'(bus_b.oFrameCount), 32'd1);
    check("s6_timeout",   32'(bus_b.oTimeout),    32'd0);
    check("s6_gap",       32'({bus_b.oBusy, bus_b.oDrawEnable}), 32'd2);
    tick(); tick();

    // Frame counter wraps 255 -> 0
    for (int i = 0; i < 255; i++) b_force_draw();
    check("wrap_count",   32'(bus_b.oFrameCount), 32'd0);
    check("wrap_timeout", 32'(bus_b.oTimeout),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
